// File: rtl/vga_pixel_output.sv
// -----------------------------------------------------------------------------
// vga_pixel_output
//
// Final output stage of the VGA path. Sync/blank from the timing counters are
// delayed so they line up with the shader pipeline, then registered together
// with the shader colour. The colour is forced to 0 while blanked, and to
// UNDERRUN_COLOR on active pixels the shader failed to deliver. The stage also
// produces line/frame start strobes, a free-running frame counter and a
// sticky underrun flag.
//
// Parameters
//   DELAY          sync/blank latency in pix_en cycles incl. output register (1..15)
//   COLOR_BITS     colour width (RRGGBB)
//   FRAME_BITS     frame counter width
//   POLARITY       sync polarity, 1 = active-high, 0 = active-low
//   UNDERRUN_COLOR colour driven on active pixels with pixel_valid = 0
//
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   pix_en                     pixel-rate enable, all state advances only when 1
//   hsync_in, vsync_in         sync from timing (polarity per POLARITY)
//   hblank_in, vblank_in       blank from timing, 1 = blanked
//   pixel_in, pixel_valid      shader colour and its valid flag
//   underrun_clr               clears the sticky underrun flag
//   hsync_o, vsync_o, blank_o  delayed, registered sync/blank
//   rgb_o                      registered colour, 0 while blanked
//   line_start_o               pulse on first active pixel of a line
//   frame_start_o              pulse on first active pixel of a frame
//   frame_cnt_o                frames begun since reset
//   underrun_o                 sticky underrun flag
// -----------------------------------------------------------------------------
module vga_pixel_output #(
   parameter int                    DELAY          = 2,
   parameter int                    COLOR_BITS     = 6,
   parameter int                    FRAME_BITS     = 8,
   parameter int                    POLARITY       = 0,
   parameter logic [COLOR_BITS-1:0] UNDERRUN_COLOR = 6'b110011
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  pix_en,
   input  logic                  hsync_in,
   input  logic                  vsync_in,
   input  logic                  hblank_in,
   input  logic                  vblank_in,
   input  logic [COLOR_BITS-1:0] pixel_in,
   input  logic                  pixel_valid,
   input  logic                  underrun_clr,
   output logic                  hsync_o,
   output logic                  vsync_o,
   output logic                  blank_o,
   output logic [COLOR_BITS-1:0] rgb_o,
   output logic                  line_start_o,
   output logic                  frame_start_o,
   output logic [FRAME_BITS-1:0] frame_cnt_o,
   output logic                  underrun_o
);

   localparam logic SYNC_ACT  = (POLARITY != 0) ? 1'b1 : 1'b0;
   localparam logic SYNC_IDLE = ~SYNC_ACT;

   // Stage word: {real, hsync, vsync, hblank, vblank}. The "real" bit marks
   // samples that came from the timing inputs rather than from the reset fill,
   // so the idle fill cannot fake a blank edge or a vsync edge after reset.
   localparam logic [4:0] STAGE_IDLE = {1'b0, SYNC_IDLE, SYNC_IDLE, 1'b1, 1'b1};

   logic [4:0] w_in;
   logic [4:0] w_last;
   logic       w_real;
   logic       w_hs;
   logic       w_vs;
   logic       w_vb;
   logic       w_blank;

   assign w_in = {1'b1, hsync_in, vsync_in, hblank_in, vblank_in};

   // DELAY-1 shift stages ahead of the output register; none when DELAY = 1.
   genvar gi;
   generate
      if (DELAY > 1) begin : g_dly
         for (gi = 0; gi < DELAY - 1; gi++) begin : g_stage
            logic [4:0] r_q;
            logic [4:0] w_src;
            if (gi == 0) begin : g_first
               assign w_src = w_in;
            end else begin : g_next
               assign w_src = g_stage[gi-1].r_q;
            end
            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  r_q <= STAGE_IDLE;
               end else if (pix_en) begin
                  r_q <= w_src;
               end
            end
         end
         assign w_last = g_stage[DELAY-2].r_q;
      end else begin : g_nodly
         assign w_last = w_in;
      end
   endgenerate

   assign w_real  = w_last[4];
   assign w_hs    = w_last[3];
   assign w_vs    = w_last[2];
   assign w_vb    = w_last[0];
   assign w_blank = w_last[1] | w_last[0];

   logic                  r_hsync;
   logic                  r_vsync;
   logic                  r_blank;
   logic                  r_vblank;     // vblank of the previously loaded sample
   logic                  r_real;       // previously loaded sample was real
   logic                  r_armed;      // a real blanked sample has been loaded since reset
   logic [COLOR_BITS-1:0] r_rgb;
   logic                  r_line_start;
   logic                  r_frame_start;
   logic [FRAME_BITS-1:0] r_frame_cnt;
   logic                  r_underrun;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hsync       <= SYNC_IDLE;
         r_vsync       <= SYNC_IDLE;
         r_blank       <= 1'b1;
         r_vblank      <= 1'b1;
         r_real        <= 1'b0;
         r_armed       <= 1'b0;
         r_rgb         <= '0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_cnt   <= '0;
         r_underrun    <= 1'b0;
      end else begin
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;

         // Clear first so a coincident set below takes priority.
         if (underrun_clr) begin
            r_underrun <= 1'b0;
         end

         if (pix_en) begin
            r_hsync  <= w_hs;
            r_vsync  <= w_vs;
            r_blank  <= w_blank;
            r_vblank <= w_vb;
            r_real   <= w_real;

            if (w_blank) begin
               r_rgb <= '0;
            end else if (pixel_valid) begin
               r_rgb <= pixel_in;
            end else begin
               r_rgb <= UNDERRUN_COLOR;
            end

            if (w_real && w_blank) begin
               r_armed <= 1'b1;
            end

            // Blank falling edge at the output; a frame starts when the
            // previous sample was also vertically blanked.
            if (r_armed && r_blank && !w_blank) begin
               r_line_start  <= 1'b1;
               r_frame_start <= r_vblank;
            end

            // Count vsync inactive->active edges between real samples only.
            if (w_real && r_real && (w_vs == SYNC_ACT) && (r_vsync != SYNC_ACT)) begin
               r_frame_cnt <= r_frame_cnt + 1'b1;
            end

            if (!w_blank && !pixel_valid) begin
               r_underrun <= 1'b1;
            end
         end
      end
   end

   assign hsync_o       = r_hsync;
   assign vsync_o       = r_vsync;
   assign blank_o       = r_blank;
   assign rgb_o         = r_rgb;
   assign line_start_o  = r_line_start;
   assign frame_start_o = r_frame_start;
   assign frame_cnt_o   = r_frame_cnt;
   assign underrun_o    = r_underrun;

endmodule
